// File: rtl/packet_seq_counter_if.sv
// Control/status bundle for packet_seq_counter: the controller (master) drives
// the buttons and the bit strobe, and the sequencer (slave) returns its indices and pulses.
interface packet_seq_counter_if #(
    parameter int PKT_BITS = 32,
    parameter int NUM_PKTS = 937
);
    localparam int BIT_W = $clog2(PKT_BITS);
    localparam int PKT_W = $clog2(NUM_PKTS);

    logic             rec_start;
    logic             play_start;
    logic             stop;
    logic             bit_en;
    logic             loop;
    logic [BIT_W-1:0] bit_idx;
    logic [PKT_W-1:0] pkt_idx;
    logic [1:0]       mode;
    logic             last_bit;
    logic             pkt_done;
    logic             frame_done;
    logic             busy;

    modport master (
        output rec_start, play_start, stop, bit_en, loop,
        input  bit_idx, pkt_idx, mode, last_bit, pkt_done, frame_done, busy
    );

    modport slave (
        input  rec_start, play_start, stop, bit_en, loop,
        output bit_idx, pkt_idx, mode, last_bit, pkt_done, frame_done, busy
    );
endinterface

// File: rtl/packet_seq_counter.sv
// Bit/packet/frame sequencer for audio record and playback, with prefetch skip on playback.
// Define LOOP_EN to make the loop input select between wrapping and stopping at frame end.
module packet_seq_counter #(
    parameter int PKT_BITS = 32,
    parameter int NUM_PKTS = 937,
    parameter int PRE_PKTS = 1
) (
    input  logic                clk,
    input  logic                reset,
    packet_seq_counter_if.slave bus
);
    localparam int BIT_W = $clog2(PKT_BITS);
    localparam int PKT_W = $clog2(NUM_PKTS);
    localparam int PRE_W = (PRE_PKTS > 1) ? $clog2(PRE_PKTS) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PKT_BITS - 1);
    localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(NUM_PKTS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = (PRE_PKTS > 0) ? PRE_W'(PRE_PKTS - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REC  = 2'b01,
        PRE  = 2'b10,
        PLAY = 2'b11
    } mode_e;

    localparam mode_e PLAY_ENTRY = (PRE_PKTS > 0) ? PRE : PLAY;

    mode_e            mode_q, mode_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [PKT_W-1:0] pkt_q, pkt_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             pkt_done_q, pkt_done_d;
    logic             frame_done_q, frame_done_d;

`ifndef LOOP_EN
    logic unused_loop;
    assign unused_loop = bus.loop;
`endif

    always_comb begin
        mode_d       = mode_q;
        bit_d        = bit_q;
        pkt_d        = pkt_q;
        pre_d        = pre_q;
        pkt_done_d   = 1'b0;
        frame_done_d = 1'b0;

        if (bus.rec_start) begin
            mode_d = REC;
            bit_d  = '0;
            pkt_d  = '0;
            pre_d  = '0;
        end else if (bus.play_start) begin
            mode_d = PLAY_ENTRY;
            bit_d  = '0;
            pkt_d  = '0;
            pre_d  = '0;
        end else if (bus.stop) begin
            mode_d = IDLE;
            bit_d  = '0;
            pkt_d  = '0;
            pre_d  = '0;
        end else if (mode_q != IDLE && bus.bit_en) begin
            if (bit_q != BIT_LAST) begin
                bit_d = bit_q + BIT_W'(1);
            end else begin
                bit_d = '0;
                if (mode_q == PRE) begin
                    // Prefetch packets are consumed without advancing the frame position.
                    if (pre_q == PRE_LAST) begin
                        mode_d = PLAY;
                        pre_d  = '0;
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end else begin
                    pkt_done_d = 1'b1;
                    if (pkt_q != PKT_LAST) begin
                        pkt_d = pkt_q + PKT_W'(1);
                    end else begin
                        pkt_d        = '0;
                        frame_done_d = 1'b1;
`ifdef LOOP_EN
                        if (!bus.loop) mode_d = IDLE;
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q       <= IDLE;
            bit_q        <= '0;
            pkt_q        <= '0;
            pre_q        <= '0;
            pkt_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            bit_q        <= bit_d;
            pkt_q        <= pkt_d;
            pre_q        <= pre_d;
            pkt_done_q   <= pkt_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.bit_idx    = bit_q;
    assign bus.pkt_idx    = pkt_q;
    assign bus.mode       = mode_q;
    assign bus.last_bit   = (bit_q == BIT_LAST) && (mode_q != IDLE);
    assign bus.pkt_done   = pkt_done_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (mode_q != IDLE);
endmodule
